instr_decode: RTL and testbench

- Pipelined instruction-decode stage that sits directly upstream of the immediate extender and the ALU operand mux.
- Accepts 32-bit MIPS-style instruction words from fetch over a valid/ready handshake and splits them into register fields.
- Produces `imm16` plus the `imm_sel` control that drives the extender's `sel` input (1 = sign-extend).
- Flags unsupported opcodes and supports pipeline flush from branch resolution.

---
 rtl/instr_decode_if.sv | 36 +++
 rtl/instr_decode.sv | 125 ++++++++++++
 tb/tb_instr_decode.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_if.sv
// instr_decode_if: fetch-side and downstream-side handshake bundle for instr_decode.
// master = fetch/consumer side (drives in_*, flush, out_ready); slave = the decode stage.
interface instr_decode_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [15:0]     imm16;
    logic            imm_sel;
    logic            is_rtype;
    logic            illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rs, rt, rd,
        input  shamt, funct, imm16, imm_sel, is_rtype, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, opcode, rs, rt, rd,
        output shamt, funct, imm16, imm_sel, is_rtype, illegal
    );
endinterface

// File: rtl/instr_decode.sv
// instr_decode: registered MIPS-style decode stage; splits fields, picks imm_sel, flags illegal.
// Ports: clk, rst_n (async active-low), bus (instr_decode_if.slave). Macro INSTR_DECODE_SKID_EN adds a skid entry.
module instr_decode #(
    parameter int PC_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_decode_if.slave bus
);
    logic [31:0]     instr_q;
    logic [PC_W-1:0] pc_q;
    logic            vld_q;
    logic            sel_q;
    logic            rty_q;
    logic            ill_q;

    logic            in_fire;
    logic            out_fire;
    logic            out_open;
    logic            load;
    logic [31:0]     ld_instr;
    logic [PC_W-1:0] ld_pc;
    logic            ld_sel;
    logic            ld_ill;

    // Returns {imm_sel, illegal}.
    function automatic logic [1:0] classify(input logic [5:0] op);
        case (op)
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h04, 6'h05, 6'h23, 6'h2B: return 2'b10;
            6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h00, 6'h02, 6'h03:        return 2'b00;
            default:                    return 2'b01;
        endcase
    endfunction

    assign out_fire = vld_q && bus.out_ready;
    assign out_open = !vld_q || bus.out_ready;
    assign in_fire  = bus.in_valid && bus.in_ready;

`ifdef INSTR_DECODE_SKID_EN
    logic [31:0]     sk_instr;
    logic [PC_W-1:0] sk_pc;
    logic            sk_vld;
    logic            rdy_q;

    assign bus.in_ready = rdy_q;

    // The skid entry is older than anything on the input, so it wins the load.
    always_comb begin
        ld_instr = bus.in_instr;
        ld_pc    = bus.in_pc;
        load     = out_open && (sk_vld || in_fire);
        if (sk_vld) begin
            ld_instr = sk_instr;
            ld_pc    = sk_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_vld   <= 1'b0;
            rdy_q    <= 1'b1;
            sk_instr <= '0;
            sk_pc    <= '0;
        end else if (bus.flush) begin
            sk_vld <= 1'b0;
            rdy_q  <= 1'b1;
        end else if (in_fire && !out_open) begin
            sk_vld   <= 1'b1;
            rdy_q    <= 1'b0;
            sk_instr <= bus.in_instr;
            sk_pc    <= bus.in_pc;
        end else if (sk_vld && out_open) begin
            sk_vld <= 1'b0;
            rdy_q  <= 1'b1;
        end
    end
`else
    assign bus.in_ready = out_open;

    always_comb begin
        ld_instr = bus.in_instr;
        ld_pc    = bus.in_pc;
        load     = in_fire;
    end
`endif

    assign {ld_sel, ld_ill} = classify(ld_instr[31:26]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            sel_q   <= 1'b0;
            rty_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else if (bus.flush) begin
            vld_q <= 1'b0;
        end else if (load) begin
            vld_q   <= 1'b1;
            instr_q <= ld_instr;
            pc_q    <= ld_pc;
            sel_q   <= ld_sel;
            rty_q   <= (ld_instr[31:26] == 6'h00);
            ill_q   <= ld_ill;
        end else if (out_fire) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_pc    = pc_q;
    assign bus.opcode    = instr_q[31:26];
    assign bus.rs        = instr_q[25:21];
    assign bus.rt        = instr_q[20:16];
    assign bus.rd        = instr_q[15:11];
    assign bus.shamt     = instr_q[10:6];
    assign bus.funct     = instr_q[5:0];
    assign bus.imm16     = instr_q[15:0];
    assign bus.imm_sel   = sel_q;
    assign bus.is_rtype  = rty_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed vectors plus reset, back-pressure and flush sequences for instr_decode.
// Builds with or without INSTR_DECODE_SKID_EN.
module tb_instr_decode;
    localparam int PC_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_decode_if #(.PC_W(PC_W)) bus ();

    instr_decode #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic        isel;
        logic        rtype;
        logic        ill;
    } vec_t;

    vec_t vecs [12];

    int n_chk = 0;
    int n_fail = 0;
    int n_out = 0;
    logic acc = 1'b0;
    logic stall_prev = 1'b0;
    logic [63:0] snap = '0;
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, score, then return at posedge+1.
    task automatic cycle();
        logic [63:0] cur;
        @(negedge clk);
        cur = {bus.out_pc, bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
        if (bus.out_valid && !bus.out_ready && stall_prev)
            chk("stable", cur, snap);
        stall_prev = bus.out_valid && !bus.out_ready;
        snap = cur;
        acc = bus.in_valid && bus.in_ready && !bus.flush;
        if (bus.flush) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dup: got %h expected nothing", cur);
                end else begin
                    chk("order", cur, exp_q.pop_front());
                end
            end
            if (acc) exp_q.push_back({bus.in_pc, bus.in_instr});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_instr [4];
        int idx;
        int c;

        vecs[0]  = '{32'h2108FFFC, 6'h08, 5'd8,  5'd8, 5'd31, 5'd31, 6'h3C, 16'hFFFC, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'h3508FFFF, 6'h0D, 5'd8,  5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'hFC000000, 6'h3F, 5'd0,  5'd0, 5'd0,  5'd0,  6'h00, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h00221820, 6'h00, 5'd1,  5'd2, 5'd3,  5'd0,  6'h20, 16'h1820, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h8FA90004, 6'h23, 5'd29, 5'd9, 5'd0,  5'd0,  6'h04, 16'h0004, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h3C081234, 6'h0F, 5'd0,  5'd8, 5'd2,  5'd8,  6'h34, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h1022FFFF, 6'h04, 5'd1,  5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h08000010, 6'h02, 5'd0,  5'd0, 5'd0,  5'd0,  6'h10, 16'h0010, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h04000000, 6'h01, 5'd0,  5'd0, 5'd0,  5'd0,  6'h00, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'hAC438000, 6'h2B, 5'd2,  5'd3, 5'd16, 5'd0,  6'h00, 16'h8000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h2C000001, 6'h0B, 5'd0,  5'd0, 5'd0,  5'd0,  6'h01, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h38000000, 6'h0E, 5'd0,  5'd0, 5'd0,  5'd0,  6'h00, 16'h0000, 1'b0, 1'b0, 1'b0};

        bp_instr[0] = 32'h2108FFFC;
        bp_instr[1] = 32'h00221820;
        bp_instr[2] = 32'h3508FFFF;
        bp_instr[3] = 32'h8FA90004;

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_imm16", 64'(bus.imm16), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed decode vectors, streamed back to back
        for (int i = 0; i < 12; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_instr  = vecs[i].instr;
            bus.in_pc     = 32'h1000 + 32'(i * 4);
            bus.out_ready = 1'b1;
            cycle();
            chk("accept", 64'(acc), 64'd1);
            chk("fields", 64'({bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}),
                64'({vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].fn}));
            chk("imm16", 64'(bus.imm16), 64'(vecs[i].imm));
            chk("ctrl", 64'({bus.imm_sel, bus.is_rtype, bus.illegal, bus.out_valid}),
                64'({vecs[i].isel, vecs[i].rtype, vecs[i].ill, 1'b1}));
            chk("pc", 64'(bus.out_pc), 64'(32'h1000 + 32'(i * 4)));
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        chk("drain", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);

        // Back-pressure: 4 instructions, out_ready low for 3 cycles
        n_out = 0;
        idx = 0;
        c = 0;
        bus.out_ready = 1'b0;
        while ((idx < 4 || exp_q.size() != 0) && c < 30) begin
            bus.out_ready = (c >= 3);
            bus.in_valid  = (idx < 4);
            bus.in_instr  = bp_instr[idx & 3];
            bus.in_pc     = 32'h4000 + 32'(idx * 4);
            cycle();
            if (acc) idx++;
            if (c == 0) begin
`ifdef INSTR_DECODE_SKID_EN
                chk("bp_ready_1st", 64'(bus.in_ready), 64'd1);
`else
                chk("bp_ready_1st", 64'(bus.in_ready), 64'd0);
`endif
            end
            if (c == 1) chk("bp_ready_2nd", 64'(bus.in_ready), 64'd0);
            c++;
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 64'(n_out), 64'd4);
        chk("bp_sent", 64'(idx), 64'd4);

        // Flush with a held output and a new input in the same cycle
        cycle();
        n_out = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h2108FFFC;
        bus.in_pc     = 32'h300;
        cycle();
        chk("fl_held", 64'(bus.out_valid), 64'd1);
        bus.in_instr = 32'h3508FFFF;
        bus.in_pc    = 32'h304;
        bus.flush    = 1'b1;
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        cycle();
        chk("fl_idle", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00221820;
        bus.in_pc    = 32'h308;
        cycle();
        bus.in_valid = 1'b0;
        chk("fl_next_pc", 64'(bus.out_pc), 64'h308);
        chk("fl_next_valid", 64'(bus.out_valid), 64'd1);
        cycle();
        cycle();
        chk("fl_count", 64'(n_out), 64'd1);

        // Async reset with an instruction held in the output register
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h2108FFFC;
        bus.in_pc     = 32'h500;
        cycle();
        bus.in_valid = 1'b0;
        chk("mr_held", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mr_imm16", 64'(bus.imm16), 64'd0);
        bus.out_ready = 1'b1;
        cycle();
        chk("mr_idle", 64'(bus.out_valid), 64'd0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
